// File: rtl/tpa_twm_master.sv
// tpa_twm_master: Two-Wire Protocol initiator that serialises register writes/reads onto SDA
// and deserialises read responses after the slave's 1->0 marker.
module tpa_twm_master #(
    parameter int IDLE_GAP     = 2,
    parameter int RESP_TIMEOUT = 8,
    parameter int RESET_QUIET  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_req,
    output logic        cmd_rdy,
    input  logic        cmd_wr,
    input  logic [7:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic [15:0] cmd_rdata,
    output logic        cmd_err,
    output logic        busy,
    output logic        SCL,
    inout  wire         SDA
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] OP    = 3'd2;
    localparam logic [2:0] ADDR  = 3'd3;
    localparam logic [2:0] WDATA = 3'd4;
    localparam logic [2:0] TURN  = 3'd5;
    localparam logic [2:0] RDATA = 3'd6;
    localparam logic [2:0] GAP   = 3'd7;
    localparam int CW = $clog2(RESET_QUIET + IDLE_GAP + RESP_TIMEOUT + 17);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          wr;
    logic [7:0]    addr_sr;
    logic [15:0]   data_sr;
    logic          seen_hi;
    logic          sda_low;
    logic          drive;
    logic          sda_out;

    // a floating line reads as non-zero; only a driven 0 counts as 0
    assign sda_low = (SDA == 1'b0);
    assign drive   = (state != TURN) && (state != RDATA);
    assign sda_out = state == START ? 1'b0 :
                     state == OP    ? wr :
                     state == ADDR  ? addr_sr[0] :
                     state == WDATA ? data_sr[0] : 1'b1;
    assign SDA  = drive ? sda_out : 1'bz;
    assign SCL  = (state == IDLE) || (state == GAP);
    assign busy = state != IDLE;

    always_ff @(posedge clk) begin
        cmd_rdy <= 1'b0;
        if (reset) begin
            state     <= GAP;
            cnt       <= CW'(RESET_QUIET);
            cmd_rdata <= '0;
            cmd_err   <= 1'b0;
            wr        <= 1'b0;
            addr_sr   <= '0;
            data_sr   <= '0;
            seen_hi   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_req) begin
                    state   <= START;
                    wr      <= cmd_wr;
                    addr_sr <= cmd_addr;
                    data_sr <= cmd_wdata;
                    cmd_err <= 1'b0;
                end
                START: state <= OP;
                OP: begin
                    state <= ADDR;
                    cnt   <= '0;
                end
                ADDR: begin
                    addr_sr <= addr_sr >> 1;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(7)) begin
                        state   <= wr ? WDATA : TURN;
                        cnt     <= '0;
                        seen_hi <= 1'b0;
                    end
                end
                WDATA: begin
                    data_sr <= data_sr >> 1;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(15)) begin
                        state   <= GAP;
                        cnt     <= CW'(IDLE_GAP);
                        cmd_rdy <= 1'b1;
                    end
                end
                TURN: begin
                    seen_hi <= !sda_low;
                    cnt     <= cnt + 1'b1;
                    if (seen_hi && sda_low) begin
                        state <= RDATA;
                        cnt   <= '0;
                    end else if (cnt == CW'(RESP_TIMEOUT - 1)) begin
                        // a silent slave may still be mid-frame, so drain with the long quiet period
                        state     <= GAP;
                        cnt       <= CW'(RESET_QUIET);
                        cmd_err   <= 1'b1;
                        cmd_rdata <= '0;
                        cmd_rdy   <= 1'b1;
                    end
                end
                RDATA: begin
                    data_sr <= {!sda_low, data_sr[15:1]};
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(15)) begin
                        state     <= GAP;
                        cnt       <= CW'(IDLE_GAP);
                        cmd_rdata <= {!sda_low, data_sr[15:1]};
                        cmd_rdy   <= 1'b1;
                    end
                end
                default: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= CW'(1)) state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/tpa_twm_master.md
Name: tpa_twm_master

Overview:
- Two-Wire Protocol initiator: the host-side master that issues register writes and reads to the TPA slave over SDA, one bit per clk.
- Takes single-word commands on a req/rdy register-style port and serialises START, opcode, address and data.
- For reads, releases SDA, detects the slave's 1→0 response marker, then deserialises 16 data bits.
- Sits in the test/host subsystem, facing the TPA slave on a shared pulled-up SDA line.

Parameters:
- IDLE_GAP, 2: minimum cycles SDA is held high between transactions.
- RESP_TIMEOUT, 8: maximum TURN cycles to wait for the read-response marker.
- RESET_QUIET, 32: SDA-high cycles after reset or timeout before any START, so an in-flight slave transaction drains.

Ports:
- clk  in  1  single clock; SDA bits change and are sampled on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_req  in  1  command request (level).
- cmd_rdy  out  1  one-cycle completion pulse.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  8  register address.
- cmd_wdata  in  16  write data.
- cmd_rdata  out  16  read data; held until the next read completes.
- cmd_err  out  1  read timeout flag; valid with cmd_rdy, held until next accept.
- busy  out  1  high when state != IDLE.
- SCL  out  1  frame indicator: 0 from START through RDATA, 1 otherwise; the slave ignores it.
- SDA  inout  1  driven 0/1 by the master except in TURN/RDATA, where it is 1'bz.

Behaviour:
- Reset (synchronous, active-high):
  - state = GAP; gap counter = RESET_QUIET; SDA driven 1; SCL = 1.
  - cmd_rdy = 0, cmd_rdata = 0, cmd_err = 0, busy = 1 until the gap expires.
- States: IDLE, START, OP, ADDR, WDATA, TURN, RDATA, GAP.
- IDLE:
  - SDA = 1.
  - If cmd_req is sampled high at edge k: latch cmd_wr/cmd_addr/cmd_wdata, clear cmd_err, enter START for cycle k.
- Frame timing (k = START cycle; all fields LSB first):
  - k: SDA = 0 (START).
  - k+1: SDA = cmd_wr (OP).
  - k+2..k+9: address bits 0..7 (ADDR).
- Write: data bits 0..15 on k+10..k+25 (WDATA); GAP from k+26; cmd_rdy = 1 in cycle k+26. Total 26 cycles.
- Read:
  - TURN from k+10, SDA released.
  - Marker = SDA sampled 1 in one cycle and 0 in the next.
  - Compliant slave: z at k+10..k+11, 1 at k+12, 0 at k+13. RDATA samples bits 0..15 at k+14..k+29.
  - GAP from k+30; cmd_rdata updated and cmd_rdy = 1 in cycle k+30.
  - A later marker shifts the whole capture window accordingly. Only SDA == 0 counts as 0; sampled z counts as non-0.
- Timeout:
  - TURN cycle counter starts at 0 on entry.
  - If RESP_TIMEOUT cycles pass without a marker: cmd_err = 1, cmd_rdata = 16'h0000, cmd_rdy pulses, enter GAP with counter = RESET_QUIET.
- GAP:
  - SDA = 1. Normal entry loads IDLE_GAP.
  - Decrement each cycle; go to IDLE on the cycle the counter reaches 0.
  - cmd_req is not accepted in GAP.
- cmd_req still high in IDLE after a completion starts a new transaction with the current inputs; requesters drop cmd_req after cmd_rdy.
- cmd_req changes mid-transaction are ignored because inputs are latched.
- Reset mid-transaction: SDA = 1 from the next cycle, no cmd_rdy, RESET_QUIET honoured before any START.
- Master never drives SDA in a cycle where the slave may drive it: k+10..k+29 for a nominal read, the full TURN/RDATA window otherwise.

Test Plan:
1. Write addr 0x5A, data 0xBEEF.
   - SDA on k..k+25 = 0; 1; 0,1,0,1,1,0,1,0; 1,1,1,1, 0,1,1,1, 0,1,1,1, 1,1,0,1.
   - cmd_rdy only at k+26; cmd_err = 0.
2. Read addr 0x03, slave model holding 0x1234.
   - SDA on k..k+9 = 0; 0; 1,1,0,0,0,0,0,0; master drives z on k+10..k+29.
   - cmd_rdata = 0x1234 and cmd_rdy at k+30; SDA = 1 at k+30.
3. cmd_req held high across write 0x10←0xA5A5 then read 0x10.
   - Second START exactly IDLE_GAP + 1 cycles after the first cmd_rdy.
   - Read returns 0xA5A5.
4. Read with no responder (SDA pulled high).
   - cmd_err = 1, cmd_rdata = 0, cmd_rdy at k+18.
   - No START for the following RESET_QUIET cycles.
5. reset asserted for 1 cycle at k+15 of a write.
   - SDA = 1 from k+16; no cmd_rdy.
   - Next START no earlier than RESET_QUIET cycles after reset deasserts, even with cmd_req high.
6. Slave model delays the marker by 2 cycles (0 at k+15), returning 0x8001.
   - Capture on k+16..k+31; cmd_rdata = 0x8001 at k+32; cmd_err = 0.
